// File: rtl/tmrgen_pkg.sv
// Shared definitions for the expiry timer family: state encoding and mode constants.
package tmrgen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tmr_state_t;

    localparam logic TMR_PERIODIC = 1'b0;
    localparam logic TMR_ONESHOT  = 1'b1;

endpackage

// File: rtl/tmrgen_irq.sv
// Sticky interrupt flag with overrun detection; reusable by any single-cycle event source.
module tmrgen_irq (
    input  logic clk,
    input  logic rst_n,
    input  logic evt,
    input  logic ack,
    output logic irq,
    output logic ovr
);

    logic irq_reg;
    logic ovr_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_reg <= 1'b0;
            ovr_reg <= 1'b0;
        end else begin
            // A new event outranks an ack, so an event racing the ack is never lost.
            if (evt)
                irq_reg <= 1'b1;
            else if (ack)
                irq_reg <= 1'b0;

            if (ack)
                ovr_reg <= 1'b0;
            else if (evt && irq_reg)
                ovr_reg <= 1'b1;
        end
    end

    assign irq = irq_reg;
    assign ovr = ovr_reg;

endmodule

// File: rtl/tmrgen32.sv
// Programmable expiry timer: counts inc ticks down from a shadowed period and raises
// a one-cycle evt plus sticky irq/overrun flags on expiry, periodically or once.
module tmrgen32
    import tmrgen_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_mode,
    input  logic             cfg_wr,
    input  logic             ctl_start,
    input  logic             ctl_stop,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] cnt_cur,
    output logic             running,
    output logic             evt,
    output logic             irq,
    output logic             irq_ovr
);

    tmr_state_t       state_reg;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] sh_period_reg;
    logic             sh_mode_reg;
    logic             act_mode_reg;
    logic             evt_reg;

    logic [WIDTH-1:0] load_period_next;
    logic             load_mode_next;
    logic             expire;

    // A write in the same cycle as a load passes straight through to the count.
    assign load_period_next = cfg_wr ? cfg_period : sh_period_reg;
    assign load_mode_next   = cfg_wr ? cfg_mode   : sh_mode_reg;

    assign expire = (state_reg == ST_RUN) && inc && !ctl_stop && !ctl_start
                    && (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            sh_period_reg <= '0;
            sh_mode_reg   <= TMR_PERIODIC;
            act_mode_reg  <= TMR_PERIODIC;
            evt_reg       <= 1'b0;
        end else begin
            evt_reg <= expire;

            if (cfg_wr) begin
                sh_period_reg <= cfg_period;
                sh_mode_reg   <= cfg_mode;
            end

            if (ctl_stop) begin
                state_reg <= ST_IDLE;
            end else if (ctl_start) begin
                state_reg    <= ST_RUN;
                cnt_reg      <= load_period_next;
                act_mode_reg <= load_mode_next;
            end else if (state_reg == ST_RUN && inc) begin
                if (cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - WIDTH'(1);
                end else if (act_mode_reg == TMR_ONESHOT) begin
                    state_reg <= ST_IDLE;
                end else begin
                    cnt_reg      <= load_period_next;
                    act_mode_reg <= load_mode_next;
                end
            end
        end
    end

    tmrgen_irq u_irq (
        .clk   (clk),
        .rst_n (rst_n),
        .evt   (expire),
        .ack   (irq_ack),
        .irq   (irq),
        .ovr   (irq_ovr)
    );

    assign cnt_cur = cnt_reg;
    assign running = (state_reg == ST_RUN);
    assign evt     = evt_reg;

endmodule

// File: tb/tb_tmrgen32.sv
// Bench for tmrgen32: directed vector table, hand-written corner sequences and a
// randomized run against a tick-counting reference model.
module tb_tmrgen32;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, inc, cfg_mode, cfg_wr, ctl_start, ctl_stop, irq_ack;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cnt_cur;
    logic         running, evt, irq, irq_ovr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tmrgen32 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (inc),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .cfg_wr     (cfg_wr),
        .ctl_start  (ctl_start),
        .ctl_stop   (ctl_stop),
        .irq_ack    (irq_ack),
        .cnt_cur    (cnt_cur),
        .running    (running),
        .evt        (evt),
        .irq        (irq),
        .irq_ovr    (irq_ovr)
    );

    typedef struct {
        logic         rst_n, inc, wr;
        logic [W-1:0] per;
        logic         mode, start, stop, ack;
        logic [W-1:0] cnt;
        logic         run, evt, irq, ovr;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic r, i, w, input int p, input logic m, s, t, a,
                     input int c, input logic ru, e, q, o);
        vec_t x;
        x.rst_n = r; x.inc = i; x.wr = w; x.per = p; x.mode = m;
        x.start = s; x.stop = t; x.ack = a;
        x.cnt = c; x.run = ru; x.evt = e; x.irq = q; x.ovr = o;
        vq.push_back(x);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] c,
                             input logic ru, e, q, o);
        chk({tag, ".cnt_cur"}, cnt_cur, c);
        chk({tag, ".running"}, W'(running), W'(ru));
        chk({tag, ".evt"},     W'(evt),     W'(e));
        chk({tag, ".irq"},     W'(irq),     W'(q));
        chk({tag, ".irq_ovr"}, W'(irq_ovr), W'(o));
    endtask

    task automatic drive(input logic r, i, w, input logic [W-1:0] p, input logic m, s, t, a);
        rst_n = r; inc = i; cfg_wr = w; cfg_period = p; cfg_mode = m;
        ctl_start = s; ctl_stop = t; irq_ack = a;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference model: the loaded period and the number of ticks consumed since load.
    // Expiry is the (period+1)th tick; cnt_cur is whatever remains.
    bit     m_run, m_irq, m_ovr, m_evt, m_mode, m_shm;
    longint m_load, m_ticks, m_sh;

    task automatic model_step(input logic r, i, w, input longint p, input logic m, s, t, a);
        longint np;
        bit     nm, fire, nirq, novr;
        if (!r) begin
            m_run = 0; m_irq = 0; m_ovr = 0; m_evt = 0; m_mode = 0; m_shm = 0;
            m_load = 0; m_ticks = 0; m_sh = 0;
        end else begin
            np   = w ? p : m_sh;
            nm   = w ? m : m_shm;
            fire = m_run && i && !t && !s && (m_ticks + 1 > m_load);
            nirq = fire ? 1'b1 : (a ? 1'b0 : m_irq);
            novr = a ? 1'b0 : ((fire && m_irq) ? 1'b1 : m_ovr);
            m_irq = nirq;
            m_ovr = novr;
            m_evt = fire;
            if (t) begin
                m_run = 0;
            end else if (s) begin
                m_run = 1; m_load = np; m_ticks = 0; m_mode = nm;
            end else if (m_run && i) begin
                if (!fire) m_ticks++;
                else if (m_mode) begin
                    m_run = 0; m_load = 0; m_ticks = 0;
                end else begin
                    m_load = np; m_ticks = 0; m_mode = nm;
                end
            end
            if (w) begin
                m_sh = p; m_shm = m;
            end
        end
    endtask

    initial begin
        int  k;
        bit  found;
        logic r, i, w, m, s, t, a;
        logic [W-1:0] p;

        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // rst inc wr per mode start stop ack | cnt run evt irq ovr
        v(0,0,0,0,0,0,0,0, 0,0,0,0,0);
        v(1,0,1,3,0,0,0,0, 0,0,0,0,0);
        v(1,1,0,0,0,1,0,0, 3,1,0,0,0);
        v(1,1,0,0,0,0,0,0, 2,1,0,0,0);
        v(1,1,0,0,0,0,0,0, 1,1,0,0,0);
        v(1,1,0,0,0,0,0,0, 0,1,0,0,0);
        v(1,1,0,0,0,0,0,0, 3,1,1,1,0);
        v(1,1,0,0,0,0,0,0, 2,1,0,1,0);
        v(1,1,0,0,0,0,0,0, 1,1,0,1,0);
        v(1,1,0,0,0,0,0,0, 0,1,0,1,0);
        v(1,1,0,0,0,0,0,0, 3,1,1,1,1);
        v(1,1,0,0,0,0,0,1, 2,1,0,0,0);
        v(1,1,0,0,0,0,0,0, 1,1,0,0,0);
        v(1,1,0,0,0,0,0,0, 0,1,0,0,0);
        v(1,1,0,0,0,0,0,1, 3,1,1,1,0);
        v(1,1,0,0,0,0,0,0, 2,1,0,1,0);
        v(1,1,0,0,0,0,0,0, 1,1,0,1,0);
        v(1,1,0,0,0,0,0,0, 0,1,0,1,0);
        v(1,1,0,0,0,0,1,0, 0,0,0,1,0);
        v(1,1,0,0,0,0,0,0, 0,0,0,1,0);
        v(1,0,0,0,0,1,1,0, 0,0,0,1,0);
        v(1,0,0,0,0,1,0,0, 3,1,0,1,0);
        v(1,1,0,0,0,0,0,0, 2,1,0,1,0);
        v(1,1,0,0,0,0,0,0, 1,1,0,1,0);
        v(1,1,1,6,0,1,0,0, 6,1,0,1,0);
        v(1,1,0,0,0,0,0,0, 5,1,0,1,0);
        v(1,0,1,1,0,0,0,0, 5,1,0,1,0);
        v(1,1,0,0,0,0,0,0, 4,1,0,1,0);
        v(1,1,0,0,0,0,0,0, 3,1,0,1,0);
        v(1,1,0,0,0,0,0,0, 2,1,0,1,0);
        v(1,1,0,0,0,0,0,0, 1,1,0,1,0);
        v(1,1,0,0,0,0,0,0, 0,1,0,1,0);
        v(1,1,0,0,0,0,0,0, 1,1,1,1,1);
        v(1,1,0,0,0,0,0,0, 0,1,0,1,1);
        v(1,1,0,0,0,0,0,0, 1,1,1,1,1);
        v(1,0,0,0,0,0,0,1, 1,1,0,0,0);
        v(1,0,1,2,1,0,0,0, 1,1,0,0,0);
        v(1,1,0,0,0,0,0,0, 0,1,0,0,0);
        v(1,1,0,0,0,0,0,0, 2,1,1,1,0);
        v(1,1,0,0,0,0,0,0, 1,1,0,1,0);
        v(1,1,0,0,0,0,0,0, 0,1,0,1,0);
        v(1,1,0,0,0,0,0,0, 0,0,1,1,1);
        v(1,1,0,0,0,0,0,0, 0,0,0,1,1);
        v(1,0,0,0,0,0,0,1, 0,0,0,0,0);
        v(1,1,1,0,0,1,0,0, 0,1,0,0,0);
        v(1,1,0,0,0,0,0,0, 0,1,1,1,0);
        v(1,1,0,0,0,0,0,1, 0,1,1,1,0);
        v(1,1,0,0,0,0,0,0, 0,1,1,1,1);
        v(1,0,0,0,0,0,1,0, 0,0,0,1,1);
        v(1,0,0,0,0,0,0,1, 0,0,0,0,0);

        foreach (vq[n]) begin
            drive(vq[n].rst_n, vq[n].inc, vq[n].wr, vq[n].per, vq[n].mode,
                  vq[n].start, vq[n].stop, vq[n].ack);
            step();
            $display("vec %0d: cnt=%0d run=%0b evt=%0b irq=%0b ovr=%0b",
                     n, cnt_cur, running, evt, irq, irq_ovr);
            check_all($sformatf("vec%0d", n), vq[n].cnt, vq[n].run, vq[n].evt,
                      vq[n].irq, vq[n].ovr);
        end

        // One-shot P=2: single evt on the fourth edge after start, then silent.
        drive(1, 1, 1, 2, 1, 1, 0, 0);
        step();
        chk("os.load_cnt", cnt_cur, 2);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        k = 1;
        found = 0;
        while (k < 12 && !found) begin
            step();
            k++;
            if (evt === 1'b1) found = 1;
        end
        $display("oneshot: evt seen=%0b after %0d edges", found, k);
        chk("os.evt_edge", W'(k), 4);
        chk("os.running", W'(running), 0);
        chk("os.cnt", cnt_cur, 0);
        for (int j = 0; j < 3; j++) begin
            step();
            chk("os.no_evt", W'(evt), 0);
            chk("os.cnt_hold", cnt_cur, 0);
        end

        // Reset mid-run at cnt_cur = 7, then shadow period must read back as 0.
        drive(1, 0, 1, 9, 0, 1, 0, 0);
        step();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("rst.pre_cnt", cnt_cur, 7);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        step();
        $display("midreset: cnt=%0d run=%0b", cnt_cur, running);
        check_all("rst.after", 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        step();
        chk("rst.sh_zero_cnt", cnt_cur, 0);
        chk("rst.sh_zero_run", W'(running), 1);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step();
        chk("p0.evt1", W'(evt), 1);
        step();
        chk("p0.evt2", W'(evt), 1);
        chk("p0.cnt", cnt_cur, 0);

        // Randomized run against the model, starting from reset.
        for (int n = 0; n < 400; n++) begin
            r = (n == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
            i = ($urandom_range(0, 99) < 75);
            w = ($urandom_range(0, 99) < 8);
            p = W'($urandom_range(0, 5));
            m = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 99) < 6);
            t = ($urandom_range(0, 99) < 4);
            a = ($urandom_range(0, 99) < 10);
            drive(r, i, w, p, m, s, t, a);
            step();
            model_step(r, i, w, longint'(p), m, s, t, a);
            $display("rnd %0d: rst_n=%0b inc=%0b wr=%0b p=%0d m=%0b st=%0b sp=%0b ack=%0b -> cnt=%0d run=%0b evt=%0b irq=%0b ovr=%0b",
                     n, r, i, w, p, m, s, t, a, cnt_cur, running, evt, irq, irq_ovr);
            check_all($sformatf("rnd%0d", n), W'(m_load - m_ticks), m_run, m_evt, m_irq, m_ovr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmrgen32.md
# tmrgen32

Programmable expiry timer: the event-generating counterpart to the capture/counter blocks. Instead of recording when an event happened, it raises an event after a programmed number of `inc` ticks. It supports periodic and one-shot modes, a shadowed period register and a latched interrupt flag with overrun detection. It sits beside the capture counters in the E1 timing path and is driven by the same prescaled `inc` strobes, for example to generate frame or multiframe deadlines and watchdog timeouts.

## Interface
- `WIDTH`, 32: counter and period width in bits (legal range 8..32).

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low. One clock domain, synchronous active-low reset; polarity and synchronicity are fixed.
- `inc`  in  1  count strobe; one tick per cycle when high.
- `cfg_period`  in  WIDTH  period value P.
- `cfg_mode`  in  1  0 = periodic, 1 = one-shot; sampled with `cfg_wr`.
- `cfg_wr`  in  1  loads `cfg_period` and `cfg_mode` into the shadow registers.
- `ctl_start`  in  1  start, or restart when already running.
- `ctl_stop`  in  1  stop; the counter freezes.
- `irq_ack`  in  1  clears `irq` and `irq_ovr`.
- `cnt_cur`  out  WIDTH  ticks remaining before expiry.
- `running`  out  1  high while in RUN.
- `evt`  out  1  one-cycle expiry pulse.
- `irq`  out  1  sticky expiry flag.
- `irq_ovr`  out  1  sticky overrun flag: an expiry occurred while `irq` was still set.

## Operation
- **Reset values:** every output is 0; shadow period = 0; shadow mode = periodic; state = IDLE.
- **Registers:**
  - The shadow registers (`sh_period`, `sh_mode`) load on `cfg_wr` in any state.
  - The active registers (`act_period`, `act_mode`) copy the shadow on start and on every periodic reload.
  - A `cfg_wr` therefore never disturbs a count in progress.
- **State IDLE:** `cnt_cur` holds its value and `inc` is ignored. `ctl_start` loads `cnt_cur` from `sh_period` and moves to RUN.
- **State RUN, on a cycle with `inc`:**
  - If `cnt_cur` != 0: decrement `cnt_cur`.
  - If `cnt_cur` == 0: expiry. `evt` pulses.
  - After a periodic expiry, `cnt_cur` reloads from `sh_period` and the active registers are refreshed.
  - After a one-shot expiry, the block returns to IDLE with `cnt_cur` = 0.
- **Period arithmetic:** one expiry every P+1 `inc` ticks. P = 0 with `inc` held high gives `evt` on every cycle. There is no wrap below 0.
- **Priority within one cycle:** `ctl_stop` > `ctl_start` > expiry or decrement.
  - Stop in the same cycle as an expiry: no `evt`; the block goes to IDLE; `cnt_cur` keeps its value.
  - Start while in RUN: reloads from `sh_period` and suppresses any expiry in that cycle.
  - `inc` in the start cycle is not counted.
- **`cfg_wr` in the same cycle as start or reload:** the new `cfg_period`/`cfg_mode` value is the one used (write-through to the active registers).
- **Interrupt flags:**
  - `irq` is set by an expiry and cleared by `irq_ack`.
  - Expiry and ack in the same cycle: `irq` stays 1 and `irq_ovr` is not set.
  - `irq_ovr` is set by an expiry while `irq` = 1 and no ack is present. It is cleared by `irq_ack` only.
- **Mid-operation reset:** `rst_n` low forces the reset values on the next edge, regardless of state.

## Timing
- All outputs are registered.
- `evt`, `irq`, `irq_ovr` and the reloaded `cnt_cur` appear on the edge that ends the expiring cycle, so latency from the expiring `inc` is one cycle.
- `running` rises on the edge that samples `ctl_start` and falls on the edge that samples a stop or one-shot expiry. It is high in the same cycle that `cnt_cur` shows P.
- `cnt_cur` is valid every cycle. It has no combinational path from any input.

## Structure
- **Shared package `tmrgen_pkg`:**
  - state encoding (IDLE = 1'b0, RUN = 1'b1);
  - mode constants (`TMR_PERIODIC` = 0, `TMR_ONESHOT` = 1).
- **Sub-module `tmrgen_irq`:** the irq/ovr flag pair.
  - Inputs: `clk`, `rst_n`, `evt`, `ack`.
  - Outputs: `irq`, `ovr`.
  - Reused by other event sources in the design.
- **Counter:** plain fabric logic, no SB_MAC16. The reload and priority muxing do not map onto the MAC output register.

## Test plan
- **Periodic run:** P = 3, periodic, `inc` = 1, start at cycle 0.
  - `cnt_cur` = 3, 2, 1, 0 on cycles 1–4.
  - `evt` at cycle 5 with `cnt_cur` = 3; repeats every 4 cycles.
- **One-shot:** P = 2, one-shot, start, `inc` = 1.
  - Single `evt` at cycle 4.
  - `running` falls at cycle 4; `cnt_cur` stays 0; further `inc` produces no `evt`.
- **Shadow update:** P = 5 running, `cfg_wr` with P = 1 mid-count.
  - The current period completes after 6 ticks.
  - Subsequent period is 2 ticks.
- **Priority:** `ctl_stop` in the expiring cycle gives no `evt` and IDLE. `ctl_start` and `ctl_stop` together give IDLE. Restart at `cnt_cur` = 1 reloads P with no `evt`.
- **Interrupt flags:** two expiries without ack give `irq` = 1, `irq_ovr` = 1. Ack clears both. Ack in the same cycle as an expiry gives `irq` = 1, `irq_ovr` = 0.
- **Reset mid-run:** `rst_n` = 0 for one cycle with `cnt_cur` = 7 gives all outputs 0, IDLE and shadow period 0 on the next cycle. Also covers P = 0 with `inc` = 1, which must give `evt` on every cycle.
